// File: rtl/svm_matmul2_ctrl.sv
// ---------------------------------------------------------------------------
// svm_matmul2_ctrl
// Sequencer for the second SVM matrix-multiply stage (support vector x alpha
// accumulate). Once the first-stage kernel vector is valid it sweeps the
// video alphas, idles one cycle so the datapath accumulator can clear, then
// sweeps the audio alphas. It then waits for both datapath completion
// strobes and presents `done` until the downstream stage accepts it.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   matmul1_valid / _ready    upstream handshake (ready high only in IDLE)
//   v_alpha_addr/a_alpha_addr alpha ROM addresses
//   v/a_alpha_rom_data        alpha ROM read data
//   v_alpha / a_alpha         ROM data passed through to the datapath
//   comp_sidx_delay           support-vector index aligned to the ROM data
//   v/a_alpha_valid           accumulate enables aligned to the ROM data
//   matmul2_v/a_valid         datapath completion strobes
//   done / out_ready          downstream handshake (done is a level)
//   protocol_err              sticky flag for unexpected completion strobes
// ---------------------------------------------------------------------------
module svm_matmul2_ctrl #(
    parameter int NBITS         = 16,
    parameter int VSUP_WIDTH    = 64,
    parameter int ASUP_WIDTH    = 48,
    parameter int SUP_WIDTH     = 64,
    parameter int LOG_SUP_WIDTH = 6,
    parameter int ROM_LATENCY   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     matmul1_valid,
    output logic                     matmul1_ready,
    output logic [LOG_SUP_WIDTH-1:0] v_alpha_addr,
    output logic [LOG_SUP_WIDTH-1:0] a_alpha_addr,
    input  logic [NBITS-1:0]         v_alpha_rom_data,
    input  logic [NBITS-1:0]         a_alpha_rom_data,
    output logic [NBITS-1:0]         v_alpha,
    output logic [NBITS-1:0]         a_alpha,
    output logic [LOG_SUP_WIDTH-1:0] comp_sidx_delay,
    output logic                     v_alpha_valid,
    output logic                     a_alpha_valid,
    input  logic                     matmul2_v_valid,
    input  logic                     matmul2_a_valid,
    output logic                     done,
    input  logic                     out_ready,
    output logic                     protocol_err
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_V_RUN    = 3'd1;
    localparam logic [2:0] ST_GAP      = 3'd2;
    localparam logic [2:0] ST_A_RUN    = 3'd3;
    localparam logic [2:0] ST_DRAIN    = 3'd4;
    localparam logic [2:0] ST_WAIT_OUT = 3'd5;

    // Sweep lengths are clamped to the index space the ROM can address.
    localparam int V_CNT = (VSUP_WIDTH < SUP_WIDTH) ? VSUP_WIDTH : SUP_WIDTH;
    localparam int A_CNT = (ASUP_WIDTH < SUP_WIDTH) ? ASUP_WIDTH : SUP_WIDTH;
    localparam logic [LOG_SUP_WIDTH-1:0] V_LAST = LOG_SUP_WIDTH'(V_CNT - 1);
    localparam logic [LOG_SUP_WIDTH-1:0] A_LAST = LOG_SUP_WIDTH'(A_CNT - 1);
    localparam logic [LOG_SUP_WIDTH-1:0] IDX_ZERO = LOG_SUP_WIDTH'(0);
    localparam logic [LOG_SUP_WIDTH-1:0] IDX_ONE  = LOG_SUP_WIDTH'(1);

    logic [2:0]               state_r;
    logic [2:0]               state_nx_s;
    logic [LOG_SUP_WIDTH-1:0] sidx_r;
    logic [LOG_SUP_WIDTH-1:0] sidx_nx_s;
    logic                     issue_v_s;
    logic                     issue_a_s;
    logic                     accept_s;
    logic                     err_s;
    logic                     v_seen_r;
    logic                     a_seen_r;
    logic                     ready_r;
    logic                     done_r;
    logic                     perr_r;
    logic [LOG_SUP_WIDTH-1:0] v_addr_r;
    logic [LOG_SUP_WIDTH-1:0] a_addr_r;

    // Stage 0 is the issue register; stages 1..ROM_LATENCY match ROM latency.
    logic                     v_pipe_r    [0:ROM_LATENCY];
    logic                     a_pipe_r    [0:ROM_LATENCY];
    logic [LOG_SUP_WIDTH-1:0] sidx_pipe_r [0:ROM_LATENCY];

    assign accept_s = matmul1_valid & ready_r;

    // Next-state, index counter and issue decode.
    always_comb begin
        state_nx_s = state_r;
        sidx_nx_s  = sidx_r;
        issue_v_s  = 1'b0;
        issue_a_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = ST_V_RUN;
                    sidx_nx_s  = IDX_ZERO;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_V_RUN: begin
                issue_v_s = 1'b1;
                if (sidx_r == V_LAST) begin
                    state_nx_s = ST_GAP;
                    sidx_nx_s  = IDX_ZERO;
                end else begin
                    sidx_nx_s  = sidx_r + IDX_ONE;
                end
            end
            ST_GAP: begin
                // One silent cycle lets the datapath accumulator clear.
                state_nx_s = ST_A_RUN;
                sidx_nx_s  = IDX_ZERO;
            end
            ST_A_RUN: begin
                issue_a_s = 1'b1;
                if (sidx_r == A_LAST) begin
                    state_nx_s = ST_DRAIN;
                    sidx_nx_s  = IDX_ZERO;
                end else begin
                    sidx_nx_s  = sidx_r + IDX_ONE;
                end
            end
            ST_DRAIN: begin
                // Count a strobe arriving this very cycle, not only the flags.
                if ((v_seen_r | matmul2_v_valid) && (a_seen_r | matmul2_a_valid)) begin
                    state_nx_s = ST_WAIT_OUT;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            ST_WAIT_OUT: begin
                if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT_OUT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                sidx_nx_s  = IDX_ZERO;
            end
        endcase
    end

    // Completion strobe is unexpected outside a run or when already seen.
    always_comb begin
        err_s = 1'b0;
        if ((state_r == ST_IDLE) || (state_r == ST_GAP) || (state_r == ST_WAIT_OUT)) begin
            err_s = matmul2_v_valid | matmul2_a_valid;
        end else begin
            err_s = (matmul2_v_valid & v_seen_r) | (matmul2_a_valid & a_seen_r);
        end
    end

    // Control state, handshake outputs, completion flags and ROM addresses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            sidx_r   <= IDX_ZERO;
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
            v_seen_r <= 1'b0;
            a_seen_r <= 1'b0;
            perr_r   <= 1'b0;
            v_addr_r <= IDX_ZERO;
            a_addr_r <= IDX_ZERO;
        end else begin
            state_r  <= state_nx_s;
            sidx_r   <= sidx_nx_s;
            ready_r  <= (state_nx_s == ST_IDLE);
            done_r   <= (state_nx_s == ST_WAIT_OUT);
            perr_r   <= perr_r | err_s;
            if (accept_s) begin
                v_seen_r <= 1'b0;
                a_seen_r <= 1'b0;
            end else begin
                v_seen_r <= v_seen_r | matmul2_v_valid;
                a_seen_r <= a_seen_r | matmul2_a_valid;
            end
            v_addr_r <= issue_v_s ? sidx_r : v_addr_r;
            a_addr_r <= issue_a_s ? sidx_r : a_addr_r;
        end
    end

    // Issue register plus ROM-latency delay line for valids and index.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= ROM_LATENCY; i++) begin
                v_pipe_r[i]    <= 1'b0;
                a_pipe_r[i]    <= 1'b0;
                sidx_pipe_r[i] <= IDX_ZERO;
            end
        end else begin
            v_pipe_r[0]    <= issue_v_s;
            a_pipe_r[0]    <= issue_a_s;
            sidx_pipe_r[0] <= (issue_v_s | issue_a_s) ? sidx_r : IDX_ZERO;
            for (int i = 1; i <= ROM_LATENCY; i++) begin
                v_pipe_r[i]    <= v_pipe_r[i-1];
                a_pipe_r[i]    <= a_pipe_r[i-1];
                sidx_pipe_r[i] <= sidx_pipe_r[i-1];
            end
        end
    end

    assign matmul1_ready   = ready_r;
    assign done            = done_r;
    assign protocol_err    = perr_r;
    assign v_alpha_addr    = v_addr_r;
    assign a_alpha_addr    = a_addr_r;
    assign v_alpha         = v_alpha_rom_data;
    assign a_alpha         = a_alpha_rom_data;
    assign v_alpha_valid   = v_pipe_r[ROM_LATENCY];
    assign a_alpha_valid   = a_pipe_r[ROM_LATENCY];
    assign comp_sidx_delay = sidx_pipe_r[ROM_LATENCY];

endmodule

// File: tb/tb_svm_matmul2_ctrl.sv
// ---------------------------------------------------------------------------
// tb_svm_matmul2_ctrl
// Three controller instances: (V=4,A=3,L=1), (V=4,A=3,L=0), (V=1,A=1,L=1).
// Each has a ROM model (registered for L=1, combinational for L=0) with
// random contents and a datapath model that strobes its completion one
// cycle after the last valid of each class. Expected traces come from the
// cycle-timing formulas of the block (accept edge = cycle 0).
// ---------------------------------------------------------------------------
module tb_svm_matmul2_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mv    [3];
    logic        ordy  [3];
    logic        inj   [3];
    logic        vd    [3];
    logic        ad    [3];
    logic        vv    [3];
    logic        av    [3];
    logic        rdy   [3];
    logic        dn    [3];
    logic        perr  [3];
    logic        mvs   [3];
    logic        mas   [3];
    logic [5:0]  vaddr [3];
    logic [5:0]  aaddr [3];
    logic [5:0]  comp  [3];
    logic [15:0] vrd   [3];
    logic [15:0] ard   [3];
    logic [15:0] vq    [3];
    logic [15:0] aq    [3];
    logic [15:0] val   [3];
    logic [15:0] aal   [3];
    logic [15:0] vrom  [64];
    logic [15:0] arom  [64];

    int errors = 0;
    int checks = 0;
    bit perr_exp [3];
    int vs [3] = '{4, 4, 1};
    int as [3] = '{3, 3, 1};
    int ls [3] = '{1, 0, 1};

    for (genvar k = 0; k < 3; k++) begin : g_inst
        // ROM and datapath-completion models for instance k.
        always @(posedge clk) begin
            vd[k] <= rst ? 1'b0 : vv[k];
            ad[k] <= rst ? 1'b0 : av[k];
            vq[k] <= vrom[vaddr[k]];
            aq[k] <= arom[aaddr[k]];
        end
        assign mvs[k] = vd[k] & ~vv[k];
        assign mas[k] = (ad[k] & ~av[k]) | inj[k];
        assign vrd[k] = (k == 1) ? vrom[vaddr[k]] : vq[k];
        assign ard[k] = (k == 1) ? arom[aaddr[k]] : aq[k];

        svm_matmul2_ctrl #(
            .NBITS(16), .VSUP_WIDTH((k == 2) ? 1 : 4), .ASUP_WIDTH((k == 2) ? 1 : 3),
            .SUP_WIDTH(64), .LOG_SUP_WIDTH(6), .ROM_LATENCY((k == 1) ? 0 : 1)
        ) u_dut (
            .clk(clk), .rst(rst),
            .matmul1_valid(mv[k]), .matmul1_ready(rdy[k]),
            .v_alpha_addr(vaddr[k]), .a_alpha_addr(aaddr[k]),
            .v_alpha_rom_data(vrd[k]), .a_alpha_rom_data(ard[k]),
            .v_alpha(val[k]), .a_alpha(aal[k]),
            .comp_sidx_delay(comp[k]),
            .v_alpha_valid(vv[k]), .a_alpha_valid(av[k]),
            .matmul2_v_valid(mvs[k]), .matmul2_a_valid(mas[k]),
            .done(dn[k]), .out_ready(ordy[k]), .protocol_err(perr[k])
        );
    end

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mv[k] = 1'b0; ordy[k] = 1'b0; inj[k] = 1'b0; perr_exp[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rdy[k] !== 1'b1 || dn[k] !== 1'b0 || vv[k] !== 1'b0 || av[k] !== 1'b0 ||
                perr[k] !== 1'b0 || comp[k] !== 6'd0 || vaddr[k] !== 6'd0 || aaddr[k] !== 6'd0) begin
                errors++;
                $display("FAIL reset_state inst=%0d got rdy=%0b done=%0b vv=%0b av=%0b perr=%0b comp=%0d exp 1,0,0,0,0,0",
                         k, rdy[k], dn[k], vv[k], av[k], perr[k], comp[k]);
            end
        end
        rst = 1'b0;
    endtask

    // Wait a random idle gap, confirm IDLE, raise matmul1_valid.
    task automatic start_op(input int s);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        checks++;
        if (rdy[s] !== 1'b1 || dn[s] !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready inst=%0d got rdy=%0b done=%0b exp 1,0", s, rdy[s], dn[s]);
        end
        mv[s] = 1'b1;
    endtask

    // One full operation whose accept edge is the next posedge. out_ready is
    // held low for `hold` cycles of done; matmul1_valid stays high meanwhile.
    task automatic run_op(input int s, input int hold, input bit keep);
        int v, a, l, d, es;
        bit ev, ea, ed, er;
        v = vs[s]; a = as[s]; l = ls[s];
        d = v + a + 3 + l;
        @(posedge clk);
        for (int c = 0; c <= d + hold + 1; c++) begin
            @(negedge clk);
            ev = (c >= 1 + l) && (c < 1 + l + v);
            ea = (c >= v + 2 + l) && (c <= v + a + 1 + l);
            es = ev ? (c - 1 - l) : (c - (v + 2 + l));
            ed = (c >= d) && (c <= d + hold);
            er = (c == d + hold + 1);
            checks++;
            if (vv[s] !== ev) begin
                errors++;
                $display("FAIL v_valid inst=%0d c=%0d got=%0b exp=%0b", s, c, vv[s], ev);
            end
            checks++;
            if (av[s] !== ea) begin
                errors++;
                $display("FAIL a_valid inst=%0d c=%0d got=%0b exp=%0b", s, c, av[s], ea);
            end
            checks++;
            if (vv[s] === 1'b1 && av[s] === 1'b1) begin
                errors++;
                $display("FAIL both_valid inst=%0d c=%0d got=1 exp=0", s, c);
            end
            checks++;
            if (dn[s] !== ed) begin
                errors++;
                $display("FAIL done inst=%0d c=%0d got=%0b exp=%0b", s, c, dn[s], ed);
            end
            checks++;
            if (rdy[s] !== er) begin
                errors++;
                $display("FAIL ready inst=%0d c=%0d got=%0b exp=%0b", s, c, rdy[s], er);
            end
            checks++;
            if (perr[s] !== perr_exp[s]) begin
                errors++;
                $display("FAIL protocol_err inst=%0d c=%0d got=%0b exp=%0b", s, c, perr[s], perr_exp[s]);
            end
            if (ev || ea) begin
                checks++;
                if (comp[s] !== 6'(es)) begin
                    errors++;
                    $display("FAIL sidx inst=%0d c=%0d got=%0d exp=%0d", s, c, comp[s], es);
                end
                checks++;
                if (ev && val[s] !== vrom[es]) begin
                    errors++;
                    $display("FAIL v_alpha inst=%0d c=%0d got=%0h exp=%0h", s, c, val[s], vrom[es]);
                end else if (ea && aal[s] !== arom[es]) begin
                    errors++;
                    $display("FAIL a_alpha inst=%0d c=%0d got=%0h exp=%0h", s, c, aal[s], arom[es]);
                end
            end
            ordy[s] = (c == d + hold);
            mv[s]   = (c <= d + hold) ? 1'b1 : keep;
        end
    endtask

    task automatic test_run_l1();
        start_op(0);
        run_op(0, 0, 1'b0);
    endtask

    task automatic test_run_l0();
        start_op(1);
        run_op(1, 0, 1'b0);
    endtask

    task automatic test_out_hold();
        start_op(0);
        run_op(0, 5, 1'b0);
    endtask

    task automatic test_reset_mid();
        start_op(0);
        @(posedge clk);
        repeat (4) @(negedge clk);
        checks++;
        if (vv[0] !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid got=%0b exp=1", vv[0]);
        end
        rst = 1'b1;
        mv[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (vv[0] !== 1'b0 || av[0] !== 1'b0 || rdy[0] !== 1'b1 || dn[0] !== 1'b0 || comp[0] !== 6'd0) begin
            errors++;
            $display("FAIL mid_reset got vv=%0b av=%0b rdy=%0b done=%0b comp=%0d exp 0,0,1,0,0",
                     vv[0], av[0], rdy[0], dn[0], comp[0]);
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) perr_exp[k] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (vv[0] !== 1'b0 || av[0] !== 1'b0 || rdy[0] !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_quiet c=%0d got vv=%0b av=%0b rdy=%0b exp 0,0,1", c, vv[0], av[0], rdy[0]);
            end
        end
        start_op(0);
        run_op(0, 0, 1'b0);
    endtask

    task automatic test_protocol_err();
        @(negedge clk);
        inj[0] = 1'b1;
        @(negedge clk);
        inj[0] = 1'b0;
        perr_exp[0] = 1'b1;
        checks++;
        if (perr[0] !== 1'b1) begin
            errors++;
            $display("FAIL perr_set got=%0b exp=1", perr[0]);
        end
        start_op(0);
        run_op(0, $urandom_range(0, 2), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) perr_exp[k] = 1'b0;
        checks++;
        if (perr[0] !== 1'b0) begin
            errors++;
            $display("FAIL perr_clear got=%0b exp=0", perr[0]);
        end
    endtask

    task automatic test_back_to_back();
        start_op(2);
        for (int i = 0; i < 4; i++) run_op(2, 0, (i < 3));
    endtask

    task automatic test_random();
        int s;
        for (int i = 0; i < 6; i++) begin
            s = $urandom_range(0, 2);
            start_op(s);
            run_op(s, $urandom_range(0, 4), 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            vrom[i] = 16'($urandom);
            arom[i] = 16'($urandom);
        end
        test_reset();
        test_run_l1();
        test_run_l0();
        test_out_hold();
        test_reset_mid();
        test_protocol_err();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
